// File: rtl/trivium_stream_w_if.sv
// Keystream bus for trivium_stream_w: key/iv load request, warm-up status,
// and a valid/ready keystream word with an accepted-word counter.
// Ports: key, iv, start, ks_ready (host -> core); busy, ks_valid,
//        ks_data[W-1:0], ks_count[31:0] (core -> host).
interface trivium_stream_w_if #(
    parameter int W = 1
);
    logic [79:0]  key;
    logic [79:0]  iv;
    logic         start;
    logic         busy;
    logic         ks_valid;
    logic         ks_ready;
    logic [W-1:0] ks_data;
    logic [31:0]  ks_count;

    modport master (
        output key, iv, start, ks_ready,
        input  busy, ks_valid, ks_data, ks_count
    );

    modport slave (
        input  key, iv, start, ks_ready,
        output busy, ks_valid, ks_data, ks_count
    );
endinterface

// File: rtl/trivium_stream_w.sv
// Trivium keystream generator producing W bits per clock step.
// Ports: clk, rst (async, active-high), bus (trivium_stream_w_if.slave):
//   key/iv/start load a stream, busy marks warm-up, ks_valid/ks_ready/
//   ks_data carry keystream words, ks_count counts accepted words.
module trivium_stream_w #(
    parameter int W      = 1,
    parameter int WARMUP = 1152
) (
    input  logic             clk,
    input  logic             rst,
    trivium_stream_w_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, RUN} fsm_t;

    localparam int unsigned STEPS = WARMUP / W;

    fsm_t         fsm;
    logic [287:0] s;
    logic [287:0] s_next;
    logic [W-1:0] z;
    logic         busy_q;
    logic         valid_q;
    logic [31:0]  ks_cnt;
    logic [31:0]  init_cnt;
    logic         t1, t2, t3;

    // Bit n of s is Trivium state bit s(n+1).
    logic [287:0] load;
    assign load = {3'b111, 112'b0, bus.iv, 13'b0, bus.key};

    // W unrolled rounds; z[j] comes from round j.
    always_comb begin
        s_next = s;
        z      = '0;
        t1     = 1'b0;
        t2     = 1'b0;
        t3     = 1'b0;
        for (int j = 0; j < W; j++) begin
            t1   = s_next[65] ^ s_next[92];
            t2   = s_next[161] ^ s_next[176];
            t3   = s_next[242] ^ s_next[287];
            z[j] = t1 ^ t2 ^ t3;
            t1   = t1 ^ (s_next[90] & s_next[91]) ^ s_next[170];
            t2   = t2 ^ (s_next[174] & s_next[175]) ^ s_next[263];
            t3   = t3 ^ (s_next[285] & s_next[286]) ^ s_next[68];
            s_next = {s_next[286:177], t2,
                      s_next[175:93], t1,
                      s_next[91:0], t3};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= IDLE;
            s        <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ks_cnt   <= '0;
            init_cnt <= '0;
        end else if (bus.start) begin
            // A new load wins over any handshake in the same cycle.
            s        <= load;
            ks_cnt   <= '0;
            init_cnt <= '0;
            if (STEPS == 0) begin
                fsm     <= RUN;
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end else begin
                fsm     <= INIT;
                busy_q  <= 1'b1;
                valid_q <= 1'b0;
            end
        end else begin
            unique case (fsm)
                IDLE: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
                INIT: begin
                    s        <= s_next;
                    init_cnt <= init_cnt + 32'd1;
                    if (init_cnt == 32'(STEPS - 1)) begin
                        fsm     <= RUN;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.ks_ready) begin
                        s      <= s_next;
                        ks_cnt <= ks_cnt + 32'd1;
                    end
                end
                default: begin
                    fsm     <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Zero state yields a zero word, so ks_data is 0 whenever reset holds.
    assign bus.ks_data  = z;
    assign bus.busy     = busy_q;
    assign bus.ks_valid = valid_q;
    assign bus.ks_count = ks_cnt;
endmodule
